nbin_unpack_ctrl: RTL
=====================

# nbin_unpack_ctrl

Sequencer for the sign-extending reduced-precision unpacker in the Proteus NBin path. It fetches packed BIT_WIDTH-bit words from the NBin buffer and loads them alternately into the unpacker's LS/MS rows. For each of `i_count` values of precision `i_prec`, it drives the unpacker's shift, width and sign-extension mask, and presents each value with a valid/ready handshake to the downstream NFU lane. One controller serves one unpacker lane.

## Interface
- `BIT_WIDTH`, 16, unpacked value width; the packed window is 2*BIT_WIDTH bits.
- `SHIFT_BITS`, 5, log2(2*BIT_WIDTH); width of `o_s`.
- `CNT_BITS`, 16, width of the value count.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: start a job; sampled only in IDLE.
- `i_prec` in SHIFT_BITS: value precision n, legal range 1..BIT_WIDTH; latched at start.
- `i_count` in CNT_BITS: number of values in the job; latched at start.
- `i_signed` in 1: enables sign extension; latched at start.
- `o_busy` out 1: high from the cycle after start until `o_done`.
- `o_done` out 1: one-cycle pulse after the last value is accepted.
- `o_rd_req` out 1: requests the next packed word.
- `i_rd_valid` in 1: word present on the unpacker `i_in` this cycle.
- `o_load` out 2: row load strobe to the unpacker; bit0 = LS row, bit1 = MS row; equals `{row==MS, row==LS} & {2{o_rd_req & i_rd_valid}}`.
- `o_s` out SHIFT_BITS: rotate-right amount, i.e. the LSB position of the current value in the window.
- `o_n` out SHIFT_BITS-1: `n[SHIFT_BITS-2:0]` (n=16 encodes as 0).
- `i_sign_bit` in 1: value MSB tapped from the unpacker.
- `o_se` out BIT_WIDTH: sign-extension mask.
- `o_out_valid` out 1: unpacker output holds a valid value.
- `i_out_ready` in 1: downstream accepts the value.

## Operation
- **States:**
  - IDLE → RUN on `i_start`.
  - RUN → DONE when the accepted count reaches `i_count`.
  - DONE (one cycle, `o_done`=1) → IDLE.
  - `i_start` is ignored outside IDLE.
  - `i_count`=0: IDLE → DONE directly, with no reads.
- **Job start:**
  - words_left = ceil(i_count*n / BIT_WIDTH), computed on CNT_BITS+SHIFT_BITS bits.
  - Bit pointer p=0, row_valid=00, next load row = LS.
- **Fetch:**
  - `o_rd_req`=1 in RUN when words_left>0 and the next load row is not valid.
  - On transfer: that row becomes valid next cycle, words_left decrements, and the next load row toggles.
  - Transfers happen only on `o_rd_req & i_rd_valid`.
- **Emit:**
  - The value occupies window bits [p, p+n) mod 2*BIT_WIDTH.
  - `o_out_valid` = RUN and every row touched by those bits has row_valid=1.
  - `o_s` = p.
- **Accept (o_out_valid & i_out_ready):**
  - p ← (p+n) mod 2*BIT_WIDTH; accepted count +1.
  - If p+n reaches or crosses a row boundary (16 or 32), the row containing p is cleared from row_valid.
  - A row freed in a cycle is requested no earlier than the next cycle.
  - A row loaded in a cycle is usable no earlier than the next cycle.
- **Sign extension:**
  - `o_se[j]` = `i_signed & i_sign_bit & (j >= n)`; all zeros when n = BIT_WIDTH or outside RUN.
- **Hold under backpressure:** while `o_out_valid & !i_out_ready`, `o_s`, `o_n` and `o_se` hold, and no row in use is reloaded.
- **Reset:** reset at any point, including mid-job, immediately returns to IDLE.

## Timing
- **Reset values:**
  - State IDLE; `o_busy`, `o_done`, `o_rd_req`, `o_out_valid` = 0.
  - `o_load` = 0, `o_s` = 0, `o_n` = 0, `o_se` = 0.
  - Counters, p and row_valid = 0.
- **Registered vs. combinational:**
  - `o_out_valid`, `o_s`, `o_n`, `o_rd_req` derive only from registered state.
  - There is no combinational path from `i_out_ready` or `i_rd_valid` to `o_out_valid` or `o_rd_req`.
  - `o_load` is the only combinational output.
  - `o_se` depends combinationally on `i_sign_bit`.
- **Start latency:** `i_start` in cycle 0 → `o_rd_req` in cycle 1 → with `i_rd_valid`=1, row LS loads at the end of cycle 1 → first `o_out_valid` in cycle 2, when n ≤ BIT_WIDTH and the value fits in LS.
- **Throughput:** one value per cycle when the word supply keeps up.
- **Done timing:** `o_done` is asserted the cycle after the last accept; `o_busy` falls in that same cycle.

## Test plan
- **Full precision:** n=16, count=3, `i_rd_valid`=1, ready=1 → 3 reads; `o_s` = 0, 16, 0; `o_load` = 01, 10, 01; `o_done` in the cycle after the third accept.
- **Four values per word:** n=4, count=8 → exactly 2 reads; `o_s` = 0, 4, 8, …, 28; 8 consecutive valid cycles once both rows are loaded.
- **Straddle and wrap:** n=5, count=7 → 3 reads. Value at p=15 waits for the MS row. Accepting it frees LS, and word 2 loads into LS. The final value at p=30 wraps bits 30..31 into 0..2 and waits for that LS reload.
- **Backpressure:** n=8, `i_out_ready` low for 5 cycles mid-job → `o_s`/`o_se` stable and no reload of the active row; the full value sequence is unchanged.
- **Sign extension:** n=6, `i_signed`=1, `i_sign_bit`=1 → `o_se`=16'hFFC0. With `i_sign_bit`=0 → `o_se`=0. With n=16 → `o_se`=0.
- **Edge cases:** `i_count`=0 → `o_done` in cycle 1 with no `o_rd_req`. `rst_n` low mid-job → all outputs 0 immediately, and a new start behaves as from reset.

Source files
------------

// File: rtl/nbin_unpack_ctrl.sv
// Sequencer for the NBin reduced-precision unpacker: fetches packed words into
// the LS/MS window rows and steps the rotate/width/sign-extension controls per value.
module nbin_unpack_ctrl #(
   parameter int BIT_WIDTH  = 16,
   parameter int SHIFT_BITS = 5,
   parameter int CNT_BITS   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic [SHIFT_BITS-1:0]   i_prec,
   input  logic [CNT_BITS-1:0]     i_count,
   input  logic                    i_signed,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_rd_req,
   input  logic                    i_rd_valid,
   output logic [1:0]              o_load,
   output logic [SHIFT_BITS-1:0]   o_s,
   output logic [SHIFT_BITS-2:0]   o_n,
   input  logic                    i_sign_bit,
   output logic [BIT_WIDTH-1:0]    o_se,
   output logic                    o_out_valid,
   input  logic                    i_out_ready
);

   localparam int WL_BITS = CNT_BITS + SHIFT_BITS;
   localparam int ROW_BIT = SHIFT_BITS - 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state_reg, state_next;
   logic [SHIFT_BITS-1:0]   prec_reg;
   logic [CNT_BITS-1:0]     count_reg;
   logic                    signed_reg;
   logic [WL_BITS-1:0]      words_left_reg;
   logic [SHIFT_BITS-1:0]   p_reg;
   logic [1:0]              row_valid_reg;
   logic                    load_row_reg;
   logic [CNT_BITS-1:0]     acc_reg;

   logic                    run;
   logic [SHIFT_BITS:0]     end_pos;
   logic                    p_row;
   logic                    e_row;
   logic [1:0]              need;
   logic                    value_ok;
   logic                    rd_req;
   logic                    transfer;
   logic                    accept;
   logic [SHIFT_BITS-1:0]   row_fill;
   logic                    crosses;
   logic [1:0]              clear_rows;
   logic [1:0]              load_rows;
   logic [CNT_BITS-1:0]     acc_next;
   logic                    last_accept;
   logic [WL_BITS-1:0]      words_init;

   assign run      = (state_reg == RUN);
   assign end_pos  = {1'b0, p_reg} + {1'b0, prec_reg} - (SHIFT_BITS+1)'(1);
   assign p_row    = p_reg[ROW_BIT];
   assign e_row    = end_pos[ROW_BIT];
   assign need     = {p_row | e_row, ~p_row | ~e_row};
   assign value_ok = run && ((row_valid_reg & need) == need);

   assign rd_req   = run && (words_left_reg != '0) && !row_valid_reg[load_row_reg];
   assign transfer = rd_req && i_rd_valid;
   assign accept   = value_ok && i_out_ready;

   // Bits of the current row at/after p plus n reaching the row size retire that row.
   assign row_fill   = {1'b0, p_reg[ROW_BIT-1:0]} + prec_reg;
   assign crosses    = (row_fill >= SHIFT_BITS'(BIT_WIDTH));
   assign clear_rows = (accept && crosses) ? {p_row, ~p_row} : 2'b00;
   assign load_rows  = {load_row_reg, ~load_row_reg} & {2{transfer}};

   assign acc_next    = acc_reg + CNT_BITS'(1);
   assign last_accept = accept && (acc_next == count_reg);

   // ceil(count*n / BIT_WIDTH) on the widened counter
   assign words_init = (WL_BITS'(i_count) * WL_BITS'(i_prec) + WL_BITS'(BIT_WIDTH - 1))
                       >> (SHIFT_BITS - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (i_start) state_next = (i_count == '0) ? DONE : RUN;
         RUN:  if (last_accept) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prec_reg       <= '0;
         count_reg      <= '0;
         signed_reg     <= 1'b0;
         words_left_reg <= '0;
         p_reg          <= '0;
         row_valid_reg  <= 2'b00;
         load_row_reg   <= 1'b0;
         acc_reg        <= '0;
      end else if (state_reg == IDLE) begin
         if (i_start) begin
            prec_reg       <= i_prec;
            count_reg      <= i_count;
            signed_reg     <= i_signed;
            words_left_reg <= words_init;
            p_reg          <= '0;
            row_valid_reg  <= 2'b00;
            load_row_reg   <= 1'b0;
            acc_reg        <= '0;
         end
      end else if (run) begin
         row_valid_reg <= (row_valid_reg & ~clear_rows) | load_rows;
         if (transfer) begin
            words_left_reg <= words_left_reg - WL_BITS'(1);
            load_row_reg   <= ~load_row_reg;
         end
         if (accept) begin
            p_reg   <= p_reg + prec_reg;
            acc_reg <= acc_next;
         end
      end
   end

   always_comb begin
      o_busy      = run;
      o_done      = (state_reg == DONE);
      o_rd_req    = rd_req;
      o_load      = load_rows;
      o_out_valid = value_ok;
      o_s         = run ? p_reg : '0;
      o_n         = run ? prec_reg[SHIFT_BITS-2:0] : '0;
   end

   // Mask bits above the value width; empty when n equals BIT_WIDTH.
   generate
      for (genvar gi = 0; gi < BIT_WIDTH; gi++) begin : g_se
         assign o_se[gi] = run && signed_reg && i_sign_bit &&
                           (SHIFT_BITS'(gi) >= prec_reg);
      end
   endgenerate

endmodule
